// File: rtl/adder_arb_pkg.sv
// ==== adder_arb_pkg: shared constants for adder_arbiter | rev 1.0 ====
`default_nettype none

package adder_arb_pkg;

  localparam int OPW       = 32;
  localparam int NOPS      = 4;
  localparam int REQ_INP_W = NOPS * OPW;
  localparam int INV_W     = NOPS;
  localparam int SCALE_W   = 2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  // Bit offset of operand op (0=a .. 3=d) belonging to requester req.
  function automatic int op_lsb(input int req, input int op);
    return req * REQ_INP_W + op * OPW;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ==== rr_arbiter: rotating-priority one-hot arbiter | rev 1.0 ====
`default_nettype none

module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int PW = $clog2(N);

  logic [PW-1:0] ptr;
  logic [PW-1:0] winner;
  logic [PW-1:0] idx;
  logic [PW:0]   sum;
  logic          found;

  // Search starts one past the last winner and wraps modulo N.
  always_comb begin
    grant  = '0;
    found  = 1'b0;
    winner = ptr;
    sum    = '0;
    idx    = '0;
    for (int i = 1; i <= N; i++) begin
      sum = {1'b0, ptr} + (PW+1)'(i);
      if (sum >= (PW+1)'(N)) begin
        sum = sum - (PW+1)'(N);
      end
      idx = sum[PW-1:0];
      if (!found && req[idx]) begin
        found      = 1'b1;
        winner     = idx;
        grant[idx] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= PW'(N - 1);
    end else if (advance && found) begin
      ptr <= winner;
    end
  end

endmodule

`default_nettype wire

// File: rtl/adder_arbiter.sv
// ==== adder_arbiter: shares one pipelined adder between NREQ requesters | rev 1.0 ====
`default_nettype none

module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter  int NREQ      = 4,
  parameter  int ADDER_LAT = 2,
  localparam int ID_W      = $clog2(NREQ)
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      enable_i,
  input  logic [NREQ-1:0]           req_valid_i,
  output logic [NREQ-1:0]           req_ready_o,
  input  logic [NREQ*REQ_INP_W-1:0] req_inp_i,
  input  logic [NREQ*INV_W-1:0]     req_invert_i,
  input  logic [NREQ*SCALE_W-1:0]   req_scale_i,
  output logic [OPW-1:0]            add_inpa_o,
  output logic [OPW-1:0]            add_inpb_o,
  output logic [OPW-1:0]            add_inpc_o,
  output logic [OPW-1:0]            add_inpd_o,
  output logic [INV_W-1:0]          add_invert_o,
  output logic [SCALE_W-1:0]        add_scale_o,
  input  logic [OPW-1:0]            add_out_i,
  output logic                      res_valid_o,
  output logic [OPW-1:0]            res_data_o,
  output logic [ID_W-1:0]           res_id_o,
  output logic                      busy_o,
  output logic [1:0]                state_o
);

  logic [1:0]         state;
  logic               issue_en;
  logic               issue;
  logic [NREQ-1:0]    grant;
  logic [ID_W-1:0]    win_id;
  logic [OPW-1:0]     sel_op [NOPS];
  logic [INV_W-1:0]   sel_inv;
  logic [SCALE_W-1:0] sel_scale;
  logic [ADDER_LAT:0] tag_valid;
  logic [ID_W-1:0]    tag_id [ADDER_LAT+1];
  logic               busy;

  // enable_i gates grants combinationally so a falling enable blocks issue that same cycle.
  assign issue_en = (state == ST_RUN) && enable_i;

  rr_arbiter #(
    .N (NREQ)
  ) u_rr (
    .clk     (clk_i),
    .rst_n   (reset_n_i),
    .req     (req_valid_i & {NREQ{issue_en}}),
    .advance (issue),
    .grant   (grant)
  );

  assign req_ready_o = grant;
  assign issue       = |grant;
  assign busy        = |tag_valid;
  assign busy_o      = busy;
  assign state_o     = state;

  always_comb begin
    win_id    = '0;
    sel_inv   = '0;
    sel_scale = '0;
    for (int k = 0; k < NOPS; k++) begin
      sel_op[k] = '0;
    end
    for (int n = 0; n < NREQ; n++) begin
      if (grant[n]) begin
        win_id    = ID_W'(n);
        sel_inv   = req_invert_i[n*INV_W +: INV_W];
        sel_scale = req_scale_i[n*SCALE_W +: SCALE_W];
        for (int k = 0; k < NOPS; k++) begin
          sel_op[k] = req_inp_i[op_lsb(n, k) +: OPW];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (enable_i) state <= ST_RUN;
        ST_RUN:   if (!enable_i) state <= ST_DRAIN;
        ST_DRAIN: begin
          if (enable_i) state <= ST_RUN;
          else if (!busy) state <= ST_IDLE;
        end
        default:  state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      add_inpa_o   <= '0;
      add_inpb_o   <= '0;
      add_inpc_o   <= '0;
      add_inpd_o   <= '0;
      add_invert_o <= '0;
      add_scale_o  <= '0;
    end else if (issue) begin
      add_inpa_o   <= sel_op[0];
      add_inpb_o   <= sel_op[1];
      add_inpc_o   <= sel_op[2];
      add_inpd_o   <= sel_op[3];
      add_invert_o <= sel_inv;
      add_scale_o  <= sel_scale;
    end
  end

  // Stage ADDER_LAT lines up with add_out_i for the transaction it tags.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      tag_valid <= '0;
      for (int k = 0; k <= ADDER_LAT; k++) begin
        tag_id[k] <= '0;
      end
    end else begin
      tag_valid <= {tag_valid[ADDER_LAT-1:0], issue};
      tag_id[0] <= win_id;
      for (int k = 1; k <= ADDER_LAT; k++) begin
        tag_id[k] <= tag_id[k-1];
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      res_valid_o <= 1'b0;
      res_data_o  <= '0;
      res_id_o    <= '0;
    end else begin
      res_valid_o <= tag_valid[ADDER_LAT];
      if (tag_valid[ADDER_LAT]) begin
        res_data_o <= add_out_i;
        res_id_o   <= tag_id[ADDER_LAT];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_adder_arbiter.sv
// ==== tb_adder_arbiter: randomized self-checking bench for adder_arbiter | rev 1.0 ====
`default_nettype none
`timescale 1ns/1ps

module tb_adder_arbiter;

  localparam int NREQ = 4;
  localparam int LAT  = 2;
  localparam int ID_W = 2;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 enable = 1'b0;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*128-1:0]  req_inp = '0;
  logic [NREQ*4-1:0]    req_invert = '0;
  logic [NREQ*2-1:0]    req_scale = '0;
  logic [31:0]          add_a, add_b, add_c, add_d, add_out;
  logic [3:0]           add_inv;
  logic [1:0]           add_scale;
  logic                 res_valid;
  logic [31:0]          res_data;
  logic [ID_W-1:0]      res_id;
  logic                 busy;
  logic [1:0]           state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  adder_arbiter #(.NREQ(NREQ), .ADDER_LAT(LAT)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .enable_i(enable),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_inp_i(req_inp), .req_invert_i(req_invert), .req_scale_i(req_scale),
    .add_inpa_o(add_a), .add_inpb_o(add_b), .add_inpc_o(add_c), .add_inpd_o(add_d),
    .add_invert_o(add_inv), .add_scale_o(add_scale), .add_out_i(add_out),
    .res_valid_o(res_valid), .res_data_o(res_data), .res_id_o(res_id),
    .busy_o(busy), .state_o(state)
  );

  function automatic logic [31:0] adder_f(input logic [127:0] ops, input logic [3:0] inv,
                                          input logic [1:0] sc);
    logic [31:0] s;
    s = 32'd0;
    for (int k = 0; k < 4; k++) s = s + (inv[k] ? ~ops[32*k +: 32] : ops[32*k +: 32]);
    return s << sc;
  endfunction

  // Two-stage adder standing in for the real datapath.
  logic [31:0] s1, s2;
  always @(posedge clk) begin
    s1 <= adder_f({add_d, add_c, add_b, add_a}, add_inv, add_scale);
    s2 <= s1;
  end
  assign add_out = s2;

  // Reference model: in-flight transactions as a queue of {due cycle, id, result}.
  typedef struct {
    int          due;
    int          id;
    logic [31:0] data;
  } item_t;

  item_t        q[$];
  int           cyc = 0;
  int           m_state, m_ptr;
  logic [31:0]  m_data;
  logic [133:0] m_add;
  logic [3:0]   exp_ready;
  logic         exp_rv, exp_busy;
  logic [1:0]   exp_state;
  logic [31:0]  exp_data;
  logic [ID_W-1:0] exp_id;
  logic [133:0] exp_add;

  task automatic model_reset();
    q.delete();
    m_state = 0;
    m_ptr   = NREQ - 1;
    m_data  = '0;
    m_add   = '0;
  endtask

  task automatic sample();
    item_t it;
    int w;
    @(negedge clk);
    cyc++;
    exp_state = 2'(m_state);
    exp_add   = m_add;
    exp_rv    = 1'b0;
    exp_id    = '0;
    if (q.size() > 0 && q[0].due == cyc) begin
      it     = q.pop_front();
      exp_rv = 1'b1;
      m_data = it.data;
      exp_id = ID_W'(it.id);
    end
    exp_data  = m_data;
    exp_busy  = (q.size() > 0);
    exp_ready = '0;
    if (m_state == 1 && enable) begin
      for (int k = 1; k <= NREQ; k++) begin
        w = (m_ptr + k) % NREQ;
        if (req_valid[w]) begin
          exp_ready[w] = 1'b1;
          it.due  = cyc + LAT + 2;
          it.id   = w;
          it.data = adder_f(req_inp[w*128 +: 128], req_invert[w*4 +: 4], req_scale[w*2 +: 2]);
          q.push_back(it);
          m_add = {req_inp[w*128 +: 128], req_invert[w*4 +: 4], req_scale[w*2 +: 2]};
          m_ptr = w;
          break;
        end
      end
    end
    case (m_state)
      0: if (enable) m_state = 1;
      1: if (!enable) m_state = 2;
      2: if (enable) m_state = 1; else if (!exp_busy) m_state = 0;
      default: m_state = 0;
    endcase
  endtask

  function automatic logic [175:0] pack_dut();
    return {req_ready, res_valid, busy, state, res_data, (res_valid ? res_id : 2'b00),
            add_d, add_c, add_b, add_a, add_inv, add_scale};
  endfunction

  function automatic logic [175:0] pack_exp();
    return {exp_ready, exp_rv, exp_busy, exp_state, exp_data, (exp_rv ? exp_id : 2'b00), exp_add};
  endfunction

  task automatic cyc_begin();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    sample();
  endtask

  task automatic rand_ops();
    for (int r = 0; r < NREQ; r++) begin
      req_inp[r*128 +: 128] = {$urandom, $urandom, $urandom, $urandom};
      req_invert[r*4 +: 4]  = 4'($urandom_range(0, 15));
      req_scale[r*2 +: 2]   = 2'($urandom_range(0, 3));
    end
  endtask

  task automatic test_reset();
    enable = 1'b0;
    req_valid = '0;
    reset_n = 1'b0;
    model_reset();
    #2;
    checks++;
    if (pack_dut() !== 176'd0) begin
      errors++;
      $display("FAIL reset_values got=%h exp=0", pack_dut());
    end
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sample();
      checks++;
      if (pack_dut() !== pack_exp()) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d got=%h exp=%h", cyc, pack_dut(), pack_exp());
      end
      cyc_begin();
    end
  endtask

  task automatic test_single();
    bit granted = 0;
    int h = 0;
    enable = 1'b0;
    req_valid = '0;
    req_inp = '0;
    req_inp[127:0] = {32'd4, 32'd3, 32'd2, 32'd1};
    req_invert = '0;
    req_scale = '0;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cyc_begin();
      enable = 1'b1;
      req_valid = granted ? 4'b0000 : 4'b0001;
      sample();
      checks++;
      if (pack_dut() !== pack_exp()) begin
        errors++;
        $display("FAIL single cyc=%0d got=%h exp=%h", cyc, pack_dut(), pack_exp());
      end
      if (!granted && exp_ready[0]) begin
        granted = 1;
        h = cyc;
      end else if (granted && cyc == h + LAT + 2) begin
        checks++;
        if (res_valid !== 1'b1 || res_data !== 32'd10 || res_id !== 2'd0) begin
          errors++;
          $display("FAIL single_result got v=%b d=%0d id=%0d exp v=1 d=10 id=0",
                   res_valid, res_data, res_id);
        end
      end
    end
    checks++;
    if (!granted) begin
      errors++;
      $display("FAIL single_grant got=none exp=grant to 0");
    end
  endtask

  task automatic test_all_valid();
    logic [3:0] order [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    logic [3:0] seen [6];
    int ng = 0;
    enable = 1'b1;
    req_valid = '0;
    do_reset();
    for (int i = 0; i < 14; i++) begin
      cyc_begin();
      req_valid = (i < 8) ? 4'b1111 : 4'b0000;
      rand_ops();
      sample();
      checks++;
      if (pack_dut() !== pack_exp()) begin
        errors++;
        $display("FAIL all_valid cyc=%0d got=%h exp=%h", cyc, pack_dut(), pack_exp());
      end
      if (req_ready !== 4'b0000 && ng < 6) begin
        seen[ng] = req_ready;
        ng++;
      end
    end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (k >= ng || seen[k] !== order[k]) begin
        errors++;
        $display("FAIL all_valid_order idx=%0d got=%b exp=%b", k, (k < ng) ? seen[k] : 4'b0, order[k]);
      end
    end
  endtask

  task automatic test_rr_skip();
    logic [3:0] vals [6] = '{4'b0010, 4'b1010, 4'b1010, 4'b1110, 4'b1110, 4'b1110};
    logic [3:0] want [6] = '{4'b0010, 4'b1000, 4'b0010, 4'b0100, 4'b1000, 4'b0010};
    enable = 1'b1;
    req_valid = '0;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      cyc_begin();
      req_valid = (i < 6) ? vals[i] : 4'b0000;
      rand_ops();
      sample();
      checks++;
      if (pack_dut() !== pack_exp()) begin
        errors++;
        $display("FAIL rr_skip cyc=%0d got=%h exp=%h", cyc, pack_dut(), pack_exp());
      end
      if (i < 6) begin
        checks++;
        if (req_ready !== want[i]) begin
          errors++;
          $display("FAIL rr_skip_grant step=%0d got=%b exp=%b", i, req_ready, want[i]);
        end
      end
    end
  endtask

  task automatic test_drain();
    int nres = 0;
    bit seen_idle = 0;
    enable = 1'b1;
    req_valid = '0;
    do_reset();
    for (int i = 0; i < 13; i++) begin
      cyc_begin();
      if (i < 3) begin
        req_valid = 4'b1111;
        rand_ops();
      end else begin
        enable = 1'b0;
      end
      sample();
      checks++;
      if (pack_dut() !== pack_exp()) begin
        errors++;
        $display("FAIL drain cyc=%0d got=%h exp=%h", cyc, pack_dut(), pack_exp());
      end
      if (res_valid === 1'b1) nres++;
      if (i > 3 && state === 2'd0) seen_idle = 1;
    end
    checks++;
    if (nres != 3 || !seen_idle) begin
      errors++;
      $display("FAIL drain_complete got results=%0d idle=%0d exp results=3 idle=1", nres, seen_idle);
    end
    req_valid = '0;
  endtask

  task automatic test_reenable();
    logic [3:0] first_g = 4'b0000;
    enable = 1'b1;
    req_valid = '0;
    do_reset();
    for (int i = 0; i < 13; i++) begin
      cyc_begin();
      req_valid = 4'b1111;
      rand_ops();
      enable = (i != 3);
      sample();
      checks++;
      if (pack_dut() !== pack_exp()) begin
        errors++;
        $display("FAIL reenable cyc=%0d got=%h exp=%h", cyc, pack_dut(), pack_exp());
      end
      if (i > 3 && first_g === 4'b0000) first_g = req_ready;
    end
    checks++;
    if (first_g !== 4'b1000) begin
      errors++;
      $display("FAIL reenable_resume got=%b exp=1000", first_g);
    end
    req_valid = '0;
  endtask

  task automatic test_reset_mid();
    logic [3:0] first_g = 4'b0000;
    enable = 1'b1;
    req_valid = '0;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      cyc_begin();
      req_valid = 4'b0110;
      rand_ops();
      sample();
      checks++;
      if (pack_dut() !== pack_exp()) begin
        errors++;
        $display("FAIL reset_mid_pre cyc=%0d got=%h exp=%h", cyc, pack_dut(), pack_exp());
      end
    end
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (pack_dut() !== 176'd0) begin
      errors++;
      $display("FAIL reset_mid_async got=%h exp=0", pack_dut());
    end
    req_valid = 4'b1111;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) cyc_begin();
      rand_ops();
      sample();
      checks++;
      if (pack_dut() !== pack_exp()) begin
        errors++;
        $display("FAIL reset_mid_post cyc=%0d got=%h exp=%h", cyc, pack_dut(), pack_exp());
      end
      if (first_g === 4'b0000) first_g = req_ready;
    end
    checks++;
    if (first_g !== 4'b0001) begin
      errors++;
      $display("FAIL reset_mid_first got=%b exp=0001", first_g);
    end
  endtask

  task automatic test_random();
    enable = 1'b1;
    req_valid = '0;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      cyc_begin();
      if ($urandom_range(0, 19) == 0) enable = ~enable;
      req_valid = 4'($urandom);
      rand_ops();
      sample();
      checks++;
      if (pack_dut() !== pack_exp()) begin
        errors++;
        $display("FAIL random cyc=%0d got=%h exp=%h", cyc, pack_dut(), pack_exp());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_valid();
    test_rr_skip();
    test_drain();
    test_reenable();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
